// File: rtl/apb_sram_slave.sv
// APB4 slave front-end for a single-port SRAM with a 1-cycle registered read.
// Handles read wait states, partial-strobe read-modify-write and PSLVERR decode.
module apb_sram_slave #(
    parameter logic [31:0] P_BASE_ADDR = 32'h4000_0000,
    parameter int unsigned P_DEPTH     = 512,
    parameter int unsigned P_AW        = 9
) (
    input  logic            iClk,
    input  logic            iRsn,
    input  logic            iPsel,
    input  logic            iPenable,
    input  logic            iPwrite,
    input  logic [31:0]     iPaddr,
    input  logic [31:0]     iPwdata,
    input  logic [3:0]      iPstrb,
    output logic [31:0]     oPrdata,
    output logic            oPready,
    output logic            oPslverr,
    output logic            oCsn,
    output logic            oWrn,
    output logic [P_AW-1:0] oAddr,
    output logic [31:0]     oWrDt,
    input  logic [31:0]     iRdDt
);

    localparam logic [31:0] WINDOW_BYTES = 32'(4 * P_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RD_CAP,
        RMW_MRG,
        DONE
    } state_t;

    state_t      state;
    logic [1:0]  step;
    logic [31:0] offset;
    logic        hit;
    logic [31:0] merged;

    // Window and alignment decode of the setup-phase address
    always_comb begin
        offset = iPaddr - P_BASE_ADDR;
        hit    = (iPaddr >= P_BASE_ADDR) && (offset < WINDOW_BYTES) && (iPaddr[1:0] == 2'b00);
    end

    // Byte merge of new write data over the word read back from the SRAM
    always_comb begin
        merged = '0;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = iPstrb[i] ? iPwdata[8*i +: 8] : iRdDt[8*i +: 8];
        end
    end

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            state    <= IDLE;
            step     <= 2'd0;
            oCsn     <= 1'b1;
            oWrn     <= 1'b1;
            oAddr    <= '0;
            oWrDt    <= '0;
            oPrdata  <= '0;
            oPready  <= 1'b0;
            oPslverr <= 1'b0;
        end else if (state != IDLE && !iPsel) begin
            // Master abandoned the transfer; any command already on the port completes now
            state    <= IDLE;
            step     <= 2'd0;
            oCsn     <= 1'b1;
            oWrn     <= 1'b1;
            oPready  <= 1'b0;
            oPslverr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    oCsn <= 1'b1;
                    step <= 2'd0;
                    if (iPsel && !iPenable) begin
                        if (!hit) begin
                            oPready  <= 1'b1;
                            oPslverr <= 1'b1;
                            oPrdata  <= '0;
                            state    <= DONE;
                        end else begin
                            oAddr <= offset[P_AW+1:2];
                            if (!iPwrite) begin
                                oCsn  <= 1'b0;
                                oWrn  <= 1'b1;
                                state <= RD_CAP;
                            end else if (iPstrb == 4'hF) begin
                                oCsn  <= 1'b0;
                                oWrn  <= 1'b0;
                                oWrDt <= iPwdata;
                                state <= DONE;
                            end else if (iPstrb == 4'h0) begin
                                oPready <= 1'b1;
                                state   <= DONE;
                            end else begin
                                oCsn  <= 1'b0;
                                oWrn  <= 1'b1;
                                state <= RMW_MRG;
                            end
                        end
                    end
                end

                RD_CAP: begin
                    oCsn <= 1'b1;
                    if (step == 2'd0) begin
                        step <= 2'd1;
                    end else begin
                        oPrdata <= iRdDt;
                        oPready <= 1'b1;
                        step    <= 2'd0;
                        state   <= DONE;
                    end
                end

                RMW_MRG: begin
                    case (step)
                        2'd0: begin
                            oCsn <= 1'b1;
                            step <= 2'd1;
                        end
                        2'd1: begin
                            oWrDt <= merged;
                            oCsn  <= 1'b0;
                            oWrn  <= 1'b0;
                            step  <= 2'd2;
                        end
                        default: begin
                            oCsn    <= 1'b1;
                            oPready <= 1'b1;
                            step    <= 2'd0;
                            state   <= DONE;
                        end
                    endcase
                end

                DONE: begin
                    // A full write enters with ready low so the SRAM write gets its own cycle
                    oCsn <= 1'b1;
                    if (!oPready) begin
                        oPready <= 1'b1;
                    end else if (iPenable) begin
                        oPready  <= 1'b0;
                        oPslverr <= 1'b0;
                        oWrn     <= 1'b1;
                        state    <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                    oCsn  <= 1'b1;
                    oWrn  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_sram_slave.sv
// Self-checking bench for apb_sram_slave: behavioural SRAM, transaction-level
// reference model, directed corner cases followed by randomized APB traffic.
module tb_apb_sram_slave;

    localparam logic [31:0] BASE  = 32'h4000_0000;
    localparam int          DEPTH = 512;

    logic        clk = 1'b0;
    logic        rsn;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic        csn, wrn;
    logic [8:0]  sramAddr;
    logic [31:0] wrDt;
    logic [31:0] rdDt;

    int nAssert = 0;
    int nFail   = 0;

    // behavioural SRAM and reference state
    logic [31:0] sram   [DEPTH];
    logic [31:0] refMem [DEPTH];
    logic [31:0] expPrdata;

    // command monitor
    int          csnCnt   = 0;
    int          csnStuck = 0;
    bit          prevLow  = 0;
    logic [8:0]  lastAddr;
    logic        lastWrn;
    logic [31:0] lastWrDt;

    logic [31:0] obsRdata;
    logic        obsErr;
    int          obsWaits;

    apb_sram_slave dut (
        .iClk    (clk),
        .iRsn    (rsn),
        .iPsel   (psel),
        .iPenable(penable),
        .iPwrite (pwrite),
        .iPaddr  (paddr),
        .iPwdata (pwdata),
        .iPstrb  (pstrb),
        .oPrdata (prdata),
        .oPready (pready),
        .oPslverr(pslverr),
        .oCsn    (csn),
        .oWrn    (wrn),
        .oAddr   (sramAddr),
        .oWrDt   (wrDt),
        .iRdDt   (rdDt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!csn) begin
            if (!wrn) sram[sramAddr] <= wrDt;
            else      rdDt <= sram[sramAddr];
        end
    end

    always @(negedge clk) begin
        if (!csn) begin
            csnCnt++;
            lastAddr = sramAddr;
            lastWrn  = wrn;
            lastWrDt = wrDt;
            if (prevLow) csnStuck++;
        end
        prevLow = !csn;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed hang, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Transaction-level expectation derived from address window, alignment and strobes
    task automatic predict(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, output int eWaits, output int ePulses,
                           output logic eErr);
        logic [31:0] mask;
        int idx;
        eErr = (addr < BASE) || (addr >= BASE + 32'(4 * DEPTH)) || (addr % 4 != 0);
        idx  = int'((addr - BASE) / 4);
        if (eErr) begin
            eWaits = 0; ePulses = 0; expPrdata = 32'h0;
        end else if (!wr) begin
            eWaits = 2; ePulses = 1; expPrdata = refMem[idx];
        end else if (strb == 4'hF) begin
            eWaits = 1; ePulses = 1; refMem[idx] = wdata;
        end else if (strb == 4'h0) begin
            eWaits = 0; ePulses = 0;
        end else begin
            mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
            eWaits = 3; ePulses = 2;
            refMem[idx] = (wdata & mask) | (refMem[idx] & ~mask);
        end
    endtask

    // One complete APB transfer, starting just after a rising edge
    task automatic doXfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input bit b2b);
        int  eWaits, ePulses, c0, waits;
        logic eErr;
        bit  seen;
        predict(wr, addr, wdata, strb, eWaits, ePulses, eErr);
        c0 = csnCnt;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0; seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (pready) seen = 1;
            else waits++;
        end
        chk("ready_timeout", 32'(seen), 32'd1);
        obsRdata = prdata; obsErr = pslverr; obsWaits = waits;
        if (seen) begin
            chk("wait_states", 32'(waits), 32'(eWaits));
            chk("pslverr", 32'(pslverr), 32'(eErr));
            chk("prdata", prdata, expPrdata);
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        chk("csn_pulses", 32'(csnCnt - c0), 32'(ePulses));
        if (!b2b) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        int c0, bad;
        logic [31:0] a, d;
        logic [3:0]  s;
        for (int i = 0; i < DEPTH; i++) begin
            refMem[i] = $urandom;
            sram[i]   = refMem[i];
        end
        expPrdata = 32'h0;
        rdDt = 32'h0;
        psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; pstrb = 0;
        rsn = 1'b1;
        #2 rsn = 1'b0;
        #1;
        chk("rst_csn", 32'(csn), 32'd1);
        chk("rst_wrn", 32'(wrn), 32'd1);
        chk("rst_addr", 32'(sramAddr), 32'd0);
        chk("rst_wrdt", wrDt, 32'h0);
        chk("rst_prdata", prdata, 32'h0);
        chk("rst_pready", 32'(pready), 32'd0);
        chk("rst_pslverr", 32'(pslverr), 32'd0);
        repeat (2) @(posedge clk);
        #1 rsn = 1'b1;
        @(posedge clk); #1;

        // full write then read
        doXfer(1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'hF, 0);
        chk("fw_addr", 32'(lastAddr), 32'd4);
        chk("fw_wrn", 32'(lastWrn), 32'd0);
        chk("fw_wrdt", lastWrDt, 32'hDEADBEEF);
        doXfer(1'b0, BASE + 32'h10, 32'h0, 4'h0, 0);
        chk("rd_data", obsRdata, 32'hDEADBEEF);

        // partial write by read-modify-write
        doXfer(1'b1, BASE + 32'h10, 32'h11223344, 4'b0101, 0);
        chk("rmw_wrdt", lastWrDt, 32'hDE22BE44);
        chk("rmw_wrn", 32'(lastWrn), 32'd0);
        doXfer(1'b0, BASE + 32'h10, 32'h0, 4'h0, 0);
        chk("rmw_readback", obsRdata, 32'hDE22BE44);

        // error transfers
        doXfer(1'b0, BASE + 32'h800, 32'h0, 4'h0, 0);
        chk("err_rd_prdata", obsRdata, 32'h0);
        chk("err_rd_slverr", 32'(obsErr), 32'd1);
        doXfer(1'b1, BASE + 32'h2, 32'hCAFEF00D, 4'hF, 0);
        chk("err_wr_slverr", 32'(obsErr), 32'd1);

        // window boundaries and zero strobe
        doXfer(1'b1, BASE + 32'h7FC, 32'hA5A5_0001, 4'hF, 0);
        chk("top_addr", 32'(lastAddr), 32'd511);
        doXfer(1'b0, BASE + 32'h7FC, 32'h0, 4'h0, 0);
        chk("top_data", obsRdata, 32'hA5A5_0001);
        doXfer(1'b1, BASE, 32'h5A5A_0002, 4'hF, 0);
        chk("bot_addr", 32'(lastAddr), 32'd0);
        doXfer(1'b0, BASE, 32'h0, 4'h0, 0);
        chk("bot_data", obsRdata, 32'h5A5A_0002);
        doXfer(1'b1, BASE + 32'h20, 32'hFFFF_FFFF, 4'h0, 0);
        chk("zs_waits", 32'(obsWaits), 32'd0);

        // access phase without setup is ignored
        c0 = csnCnt;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = BASE + 32'h20;
        repeat (3) @(posedge clk);
        #1;
        chk("nosetup_pready", 32'(pready), 32'd0);
        chk("nosetup_csn", 32'(csnCnt - c0), 32'd0);
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;

        // abort in RMW_MRG: only the read command is issued
        c0 = csnCnt;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'h24;
        pwdata = 32'h1234_5678; pstrb = 4'b0011;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        chk("abort_pready", 32'(pready), 32'd0);
        chk("abort_csn", 32'(csn), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_pulses", 32'(csnCnt - c0), 32'd1);
        doXfer(1'b0, BASE + 32'h24, 32'h0, 4'h0, 0);

        // back-to-back read, write, read of one word
        d = $urandom;
        doXfer(1'b0, BASE + 32'h40, 32'h0, 4'h0, 1);
        doXfer(1'b1, BASE + 32'h40, d, 4'hF, 1);
        doXfer(1'b0, BASE + 32'h40, 32'h0, 4'h0, 0);
        chk("b2b_data", obsRdata, d);

        // reset asserted while the read sits in RD_CAP
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = BASE + 32'h10;
        @(posedge clk); #1 penable = 1'b1;
        chk("rdcap_csn", 32'(csn), 32'd0);
        #3 rsn = 1'b0;
        #1;
        chk("midrst_csn", 32'(csn), 32'd1);
        chk("midrst_wrn", 32'(wrn), 32'd1);
        chk("midrst_addr", 32'(sramAddr), 32'd0);
        chk("midrst_wrdt", wrDt, 32'h0);
        chk("midrst_prdata", prdata, 32'h0);
        chk("midrst_pready", 32'(pready), 32'd0);
        chk("midrst_pslverr", 32'(pslverr), 32'd0);
        psel = 1'b0; penable = 1'b0;
        expPrdata = 32'h0;
        repeat (2) @(posedge clk);
        #1 rsn = 1'b1;
        c0 = csnCnt;
        repeat (5) @(posedge clk);
        #1;
        chk("postrst_csn", 32'(csnCnt - c0), 32'd0);
        chk("postrst_pready", 32'(pready), 32'd0);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0: a = BASE + 32'h800 + 32'($urandom_range(0, 255) * 4);
                1: a = BASE + 32'($urandom_range(0, 511) * 4) + 32'($urandom_range(1, 3));
                2: a = BASE - 32'(($urandom_range(1, 64)) * 4);
                default: a = BASE + 32'(($urandom_range(0, 1) != 0 ? $urandom_range(0, 15)
                                                                  : $urandom_range(0, 511)) * 4);
            endcase
            case ($urandom_range(0, 3))
                0: s = 4'hF;
                1: s = 4'h0;
                default: s = 4'($urandom_range(0, 15));
            endcase
            doXfer(1'($urandom_range(0, 1)), a, $urandom, s, bit'($urandom_range(0, 1)));
        end

        repeat (2) @(posedge clk);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (sram[i] !== refMem[i]) bad++;
        chk("mem_final", 32'(bad), 32'd0);
        chk("csn_single_cycle", 32'(csnStuck), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
